// File: rtl/tx_engine_pkg.sv
// Shared UART definitions: baud counts, FSM encodings, default port and frame builder.
// Used by tx_engine and baud_sel; rx_engine can import the same constants.
package tx_engine_pkg;

  // Rounded bit period in clocks for a given clock and line rate
  function automatic logic [17:0] baud_div(input int clk_hz, input int rate);
    baud_div = 18'((clk_hz + rate / 2) / rate);
  endfunction

  localparam logic [17:0] BAUD_CNT_0   = baud_div(50_000_000, 300);
  localparam logic [17:0] BAUD_CNT_1   = baud_div(50_000_000, 1200);
  localparam logic [17:0] BAUD_CNT_2   = baud_div(50_000_000, 2400);
  localparam logic [17:0] BAUD_CNT_3   = baud_div(50_000_000, 4800);
  localparam logic [17:0] BAUD_CNT_4   = baud_div(50_000_000, 9600);
  localparam logic [17:0] BAUD_CNT_5   = baud_div(50_000_000, 19200);
  localparam logic [17:0] BAUD_CNT_6   = baud_div(50_000_000, 38400);
  localparam logic [17:0] BAUD_CNT_7   = baud_div(50_000_000, 57600);
  localparam logic [17:0] BAUD_CNT_8   = baud_div(50_000_000, 115200);
  localparam logic [17:0] BAUD_CNT_9   = baud_div(50_000_000, 230400);
  localparam logic [17:0] BAUD_CNT_10  = baud_div(50_000_000, 460800);
  localparam logic [17:0] BAUD_CNT_11  = baud_div(50_000_000, 921600);
  localparam logic [17:0] BAUD_CNT_DEF = BAUD_CNT_8;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [15:0] TX_PORT_DEF = 16'h0000;

  // Bit 0 is the start bit; unused upper positions stay 1 so the line idles after stop
  function automatic logic [10:0] build_frame(input logic [7:0] data, input logic eight,
                                              input logic pen, input logic even);
    logic [7:0] d;
    logic       par;
    d = eight ? data : {1'b0, data[6:0]};
    par = even ? ^d : ~^d;
    build_frame = '1;
    build_frame[0] = 1'b0;
    if (eight) begin
      build_frame[8:1] = d;
      if (pen) build_frame[9] = par;
    end else begin
      build_frame[7:1] = d[6:0];
      if (pen) build_frame[8] = par;
    end
  endfunction

endpackage

// File: rtl/tx_engine_baud_sel.sv
// Baud select: maps the 4-bit baud code to a bit period in clocks (codes 12-15 = 115200).
module baud_sel
  import tx_engine_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic [3:0]  baud,
  output logic [17:0] count
);

  always_comb begin
    count = baud_div(CLK_HZ, 115200);
    case (baud)
      4'd0:    count = baud_div(CLK_HZ, 300);
      4'd1:    count = baud_div(CLK_HZ, 1200);
      4'd2:    count = baud_div(CLK_HZ, 2400);
      4'd3:    count = baud_div(CLK_HZ, 4800);
      4'd4:    count = baud_div(CLK_HZ, 9600);
      4'd5:    count = baud_div(CLK_HZ, 19200);
      4'd6:    count = baud_div(CLK_HZ, 38400);
      4'd7:    count = baud_div(CLK_HZ, 57600);
      4'd8:    count = baud_div(CLK_HZ, 115200);
      4'd9:    count = baud_div(CLK_HZ, 230400);
      4'd10:   count = baud_div(CLK_HZ, 460800);
      4'd11:   count = baud_div(CLK_HZ, 921600);
      default: count = baud_div(CLK_HZ, 115200);
    endcase
  end

endmodule

// File: rtl/tx_engine.sv
// UART transmit engine: host byte write -> start/data/parity/stop frame, LSB first.
// Optional TX_HOLD_EN adds a one-byte holding register for gapless back-to-back frames.
module tx_engine
  import tx_engine_pkg::*;
#(
  parameter logic [15:0] TX_PORT = TX_PORT_DEF,
  parameter int          CLK_HZ  = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_strobe,
  input  logic [15:0] port_id,
  input  logic [7:0]  out_port,
  input  logic        eight,
  input  logic        pen,
  input  logic        even,
  input  logic [3:0]  baud,
  output logic        tx,
  output logic        TXRDY
);

  logic [0:0]  state;
  logic [17:0] timer;
  logic [17:0] k_last;
  logic [3:0]  bit_cnt;
  logic [3:0]  last_bit;
  logic [10:0] shifter;
  logic [17:0] k_sel;
  logic        wr;
  logic        frame_end;
  logic        load;
  logic [7:0]  load_data;

  baud_sel #(.CLK_HZ(CLK_HZ)) u_baud_sel (
    .baud  (baud),
    .count (k_sel)
  );

  assign wr        = write_strobe && (port_id == TX_PORT) && TXRDY;
  assign frame_end = (state == SHIFT) && (timer == k_last) && (bit_cnt == last_bit);
  assign tx        = shifter[0];

`ifdef TX_HOLD_EN
  logic [7:0] hold_data;
  logic       hold_valid;

  assign TXRDY = ~hold_valid;
  // A write landing on the final edge of a frame goes straight into the shifter
  assign load      = ((state == IDLE) && wr) || (frame_end && (hold_valid || wr));
  assign load_data = hold_valid ? hold_data : out_port;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data  <= 8'h00;
      hold_valid <= 1'b0;
    end else if (frame_end && hold_valid) begin
      hold_valid <= 1'b0;
    end else if (wr && (state == SHIFT) && !frame_end) begin
      hold_data  <= out_port;
      hold_valid <= 1'b1;
    end
  end
`else
  assign TXRDY     = (state == IDLE);
  assign load      = (state == IDLE) && wr;
  assign load_data = out_port;
`endif

  // Shifter resets to all ones so the line is idle-high straight out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= 18'd0;
      k_last   <= 18'd0;
      bit_cnt  <= 4'd0;
      last_bit <= 4'd0;
      shifter  <= '1;
    end else if (load) begin
      state    <= SHIFT;
      timer    <= 18'd0;
      k_last   <= k_sel - 18'd1;
      bit_cnt  <= 4'd0;
      last_bit <= 4'd8 + {3'b000, eight} + {3'b000, pen};
      shifter  <= build_frame(load_data, eight, pen, even);
    end else if (state == SHIFT) begin
      if (timer == k_last) begin
        timer <= 18'd0;
        if (bit_cnt == last_bit) begin
          state   <= IDLE;
          shifter <= '1;
        end else begin
          shifter <= {1'b1, shifter[10:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        timer <= timer + 18'd1;
      end
    end
  end

endmodule

// File: tb/tb_tx_engine.sv
// Directed self-checking bench for tx_engine: frame shapes, parity, port decode, reset.
// Build with +define+TX_HOLD_EN to exercise the holding register instead of drop-on-busy.
module tb_tx_engine;

  localparam logic [15:0] TX_PORT = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_strobe = 1'b0;
  logic [15:0] port_id = 16'h0000;
  logic [7:0]  out_port = 8'h00;
  logic        eight = 1'b1;
  logic        pen = 1'b0;
  logic        even = 1'b0;
  logic [3:0]  baud = 4'd11;
  logic        tx;
  logic        txrdy;

  int n_asserts = 0;
  int n_fail = 0;

  tx_engine #(.TX_PORT(TX_PORT), .CLK_HZ(50_000_000)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_strobe (write_strobe),
    .port_id      (port_id),
    .out_port     (out_port),
    .eight        (eight),
    .pen          (pen),
    .even         (even),
    .baud         (baud),
    .tx           (tx),
    .TXRDY        (txrdy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Single write cycle; returns 1ns after the accepting edge
  task automatic apply_stimulus(input logic [15:0] pid, input logic [7:0] data);
    @(negedge clk);
    port_id = pid;
    out_port = data;
    write_strobe = 1'b1;
    @(posedge clk);
    #1;
    write_strobe = 1'b0;
  endtask

  // Samples tx every cycle for n*k cycles starting right after the load edge
  task automatic watch_frame(input string tag, input logic [10:0] exp_bits, input int n, input int k);
    logic [10:0] seen;
    logic [10:0] mask;
    int glitch;
    int busy;
    int idx;
    seen = '1;
    glitch = 0;
    busy = 0;
    mask = 11'((1 << n) - 1);
    for (int j = 0; j < n * k; j++) begin
      idx = j / k;
      if (j % k == 0) seen[idx] = tx;
      else if (tx !== seen[idx]) glitch++;
      if (txrdy === 1'b0) busy++;
      @(posedge clk);
      #1;
    end
    check_output({tag, " bits"}, 32'(seen & mask), 32'(exp_bits & mask));
    check_output({tag, " steady"}, 32'(glitch), 32'd0);
`ifdef TX_HOLD_EN
    check_output({tag, " busy"}, 32'(busy), 32'd0);
`else
    check_output({tag, " busy"}, 32'(busy), 32'(n * k));
`endif
    check_output({tag, " idle tx"}, 32'(tx), 32'd1);
    check_output({tag, " idle rdy"}, 32'(txrdy), 32'd1);
  endtask

  initial begin
    int lows;
    logic [19:0] seen2;
    int glitch2;
    int idx2;

    $display("[TB] tx_engine directed test start");
    repeat (3) @(posedge clk);
    #1;
    check_output("reset tx", 32'(tx), 32'd1);
    check_output("reset rdy", 32'(txrdy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 8N1 0x55 -> 0,1,0,1,0,1,0,1,0,1
    baud = 4'd11; eight = 1'b1; pen = 1'b0; even = 1'b0;
    apply_stimulus(TX_PORT, 8'h55);
    watch_frame("8N1 55", 11'h2AA, 10, 54);

    // 8E1 0x41 -> parity 0; config changed mid-frame must not matter
    eight = 1'b1; pen = 1'b1; even = 1'b1;
    apply_stimulus(TX_PORT, 8'h41);
    watch_frame("8E1 41", 11'h482, 11, 54);

    eight = 1'b1; pen = 1'b1; even = 1'b0;
    apply_stimulus(TX_PORT, 8'h41);
    even = 1'b1; eight = 1'b0; pen = 1'b0;
    watch_frame("8O1 41", 11'h682, 11, 54);

    // 7O1 0xFF -> seven ones, parity 0
    eight = 1'b0; pen = 1'b1; even = 1'b0;
    apply_stimulus(TX_PORT, 8'hFF);
    watch_frame("7O1 FF", 11'h2FE, 10, 54);

    // Write to another port is ignored
    eight = 1'b1; pen = 1'b0;
    apply_stimulus(16'h0001, 8'h00);
    lows = 0;
    for (int j = 0; j < 100; j++) begin
      if (tx !== 1'b1 || txrdy !== 1'b1) lows++;
      @(posedge clk);
      #1;
    end
    check_output("wrong port idle", 32'(lows), 32'd0);

`ifndef TX_HOLD_EN
    // Second write mid-frame is dropped
    apply_stimulus(TX_PORT, 8'h55);
    lows = 0;
    for (int j = 0; j < 2000 && txrdy === 1'b0; j++) begin
      if (j == 99) begin
        port_id = TX_PORT;
        out_port = 8'h00;
        write_strobe = 1'b1;
      end
      if (j == 100) write_strobe = 1'b0;
      lows++;
      @(posedge clk);
      #1;
    end
    check_output("drop busy", 32'(lows), 32'd540);
    lows = 0;
    for (int j = 0; j < 300; j++) begin
      if (tx !== 1'b1 || txrdy !== 1'b1) lows++;
      @(posedge clk);
      #1;
    end
    check_output("drop no 2nd frame", 32'(lows), 32'd0);
`endif

    // Reset at clock 200 of a frame of zeros
    apply_stimulus(TX_PORT, 8'h00);
    repeat (200) @(posedge clk);
    #1;
    check_output("pre-reset tx", 32'(tx), 32'd0);
`ifndef TX_HOLD_EN
    check_output("pre-reset rdy", 32'(txrdy), 32'd0);
`endif
    rst = 1'b1;
    #1;
    check_output("async reset tx", 32'(tx), 32'd1);
    check_output("async reset rdy", 32'(txrdy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_output("post-reset tx", 32'(tx), 32'd1);
    apply_stimulus(TX_PORT, 8'h55);
    watch_frame("after reset 55", 11'h2AA, 10, 54);

`ifdef TX_HOLD_EN
    // A5 then 3C ten clocks later: two contiguous 540-clock frames
    apply_stimulus(TX_PORT, 8'hA5);
    seen2 = '1;
    glitch2 = 0;
    for (int j = 0; j < 1080; j++) begin
      idx2 = j / 54;
      if (j % 54 == 0) seen2[idx2] = tx;
      else if (tx !== seen2[idx2]) glitch2++;
      if (j == 9) begin
        port_id = TX_PORT;
        out_port = 8'h3C;
        write_strobe = 1'b1;
      end
      if (j == 10) begin
        write_strobe = 1'b0;
        check_output("hold full", 32'(txrdy), 32'd0);
      end
      if (j == 539) check_output("hold before stop end", 32'(txrdy), 32'd0);
      if (j == 540) check_output("hold released", 32'(txrdy), 32'd1);
      @(posedge clk);
      #1;
    end
    check_output("hold bits", 32'(seen2), 32'h9E34A);
    check_output("hold steady", 32'(glitch2), 32'd0);
    check_output("hold idle tx", 32'(tx), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
